// File: rtl/ulpi_reg_sched_if.sv
// ulpi_reg_sched_if: request ports A/B, ulpi_ctl register port and status of the ULPI register scheduler
//   master: scheduler side (takes a_*/b_* requests and reg_rdy/reg_dout, drives completions, reg_* and status)
//   slave:  environment side (requesters plus ulpi_ctl)
interface ulpi_reg_sched_if;
  logic a_en, a_we, a_rdy, b_en, b_we, b_rdy;
  logic [7:0] a_addr, a_din, a_dout, b_addr, b_din, b_dout;
  logic reg_en, reg_we, reg_rdy;
  logic [7:0] reg_addr, reg_din, reg_dout;
  logic init_done, timeout;
  logic [7:0] phy_vid_lo;
  modport master (
    input  a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_din, reg_rdy, reg_dout,
    output a_rdy, a_dout, b_rdy, b_dout, reg_en, reg_we, reg_addr, reg_din, init_done, phy_vid_lo, timeout
  );
  modport slave (
    output a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_din, reg_rdy, reg_dout,
    input  a_rdy, a_dout, b_rdy, b_dout, reg_en, reg_we, reg_addr, reg_din, init_done, phy_vid_lo, timeout
  );
endinterface

// File: rtl/ulpi_reg_sched.sv
// ulpi_reg_sched: PHY init sequencer plus round-robin arbiter of two requesters onto the ulpi_ctl register port
//   ulpi_clk/ulpi_rst: clock, async active-high reset
//   bus (master): a_*/b_* request/completion, reg_* to/from ulpi_ctl, init_done/phy_vid_lo/timeout status
module ulpi_reg_sched #(
  parameter int         INIT_DELAY    = 16,
  parameter logic [7:0] FUNC_CTL_INIT = 8'h45,
  parameter logic [7:0] OTG_CTL_INIT  = 8'h00,
  parameter int         TIMEOUT       = 1023
) (
  input logic ulpi_clk,
  input logic ulpi_rst,
  ulpi_reg_sched_if.master bus
);
  typedef enum logic [2:0] {DELAY, INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT} state_e;
  state_e state_q;
  logic [15:0] dly_q, wd_q;
  logic [1:0] step_q;
  logic gnt_b_q, pend_a_q, pend_b_q, a_we_q, b_we_q;
  logic [7:0] a_addr_q, a_din_q, b_addr_q, b_din_q;
  logic reg_en_q, reg_we_q, a_rdy_q, b_rdy_q, done_q, to_q;
  logic [7:0] reg_addr_q, reg_din_q, a_dout_q, b_dout_q, vid_q;
  logic waiting, pick_b;
  // {we, addr, din} of each init step
  function automatic logic [16:0] init_op(input logic [1:0] s);
    return s == 2'd0 ? {1'b1, 8'h04, FUNC_CTL_INIT} :
           s == 2'd1 ? {1'b1, 8'h0A, OTG_CTL_INIT} : 17'd0;
  endfunction
  assign waiting = state_q == INIT_WAIT || state_q == WAIT;
  // B wins when alone, or on a tie when A had the last grant
  assign pick_b = pend_b_q && (!pend_a_q || !gnt_b_q);
  // reg_en and the op are loaded on entry to an issue state, so reg_en is high during that state
  always_ff @(posedge ulpi_clk or posedge ulpi_rst) begin
    if (ulpi_rst) begin
      state_q <= DELAY;
      dly_q <= '0;
      wd_q <= '0;
      step_q <= '0;
      gnt_b_q <= 1'b1;
      {pend_a_q, pend_b_q, a_we_q, b_we_q} <= '0;
      {a_addr_q, a_din_q, b_addr_q, b_din_q} <= '0;
      {reg_en_q, reg_we_q, a_rdy_q, b_rdy_q, done_q, to_q} <= '0;
      {reg_addr_q, reg_din_q, a_dout_q, b_dout_q, vid_q} <= '0;
    end else begin
      reg_en_q <= 1'b0;
      a_rdy_q <= 1'b0;
      b_rdy_q <= 1'b0;
      if (!pend_a_q && bus.a_en) {pend_a_q, a_we_q, a_addr_q, a_din_q} <= {1'b1, bus.a_we, bus.a_addr, bus.a_din};
      if (!pend_b_q && bus.b_en) {pend_b_q, b_we_q, b_addr_q, b_din_q} <= {1'b1, bus.b_we, bus.b_addr, bus.b_din};
      wd_q <= waiting ? (wd_q == 16'(TIMEOUT) ? wd_q : wd_q + 16'd1) : '0;
      if (waiting && !bus.reg_rdy && wd_q == 16'(TIMEOUT - 1)) to_q <= 1'b1;
      case (state_q)
        DELAY:
          if (dly_q == 16'(INIT_DELAY - 1)) begin
            state_q <= INIT_ISSUE;
            step_q <= 2'd0;
            reg_en_q <= 1'b1;
            {reg_we_q, reg_addr_q, reg_din_q} <= init_op(2'd0);
          end else dly_q <= dly_q + 16'd1;
        INIT_ISSUE: state_q <= INIT_WAIT;
        INIT_WAIT:
          if (bus.reg_rdy) begin
            if (step_q == 2'd2) begin
              vid_q <= bus.reg_dout;
              done_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              step_q <= step_q + 2'd1;
              state_q <= INIT_ISSUE;
              reg_en_q <= 1'b1;
              {reg_we_q, reg_addr_q, reg_din_q} <= init_op(step_q + 2'd1);
            end
          end
        IDLE:
          if (pend_a_q || pend_b_q) begin
            gnt_b_q <= pick_b;
            state_q <= ISSUE;
            reg_en_q <= 1'b1;
            {reg_we_q, reg_addr_q, reg_din_q} <= pick_b ? {b_we_q, b_addr_q, b_din_q} : {a_we_q, a_addr_q, a_din_q};
          end
        ISSUE: state_q <= WAIT;
        WAIT:
          if (bus.reg_rdy) begin
            if (gnt_b_q) {b_rdy_q, b_dout_q, pend_b_q} <= {1'b1, bus.reg_dout, 1'b0};
            else {a_rdy_q, a_dout_q, pend_a_q} <= {1'b1, bus.reg_dout, 1'b0};
            state_q <= IDLE;
          end
        default: state_q <= DELAY;
      endcase
    end
  end
  assign bus.reg_en = reg_en_q;
  assign bus.reg_we = reg_we_q;
  assign bus.reg_addr = reg_addr_q;
  assign bus.reg_din = reg_din_q;
  assign bus.a_rdy = a_rdy_q;
  assign bus.b_rdy = b_rdy_q;
  assign bus.a_dout = a_dout_q;
  assign bus.b_dout = b_dout_q;
  assign bus.init_done = done_q;
  assign bus.phy_vid_lo = vid_q;
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_ulpi_reg_sched.sv
// tb_ulpi_reg_sched: scoreboard bench with a model ulpi_ctl/PHY answering 6 cycles after reg_en
module tb_ulpi_reg_sched;
  logic clk, rst, phy_on, busy;
  int cyc = 0, n_vec = 0, n_err = 0, n_regen = 0;
  int t_en, t_regen, t_rrdy, t_ardy, lat;
  logic [7:0] cur;
  logic [16:0] exp_reg[$];
  logic [7:0] exp_a[$], exp_b[$];
  ulpi_reg_sched_if bus();
  ulpi_reg_sched #(.INIT_DELAY(4), .FUNC_CTL_INIT(8'h45), .OTG_CTL_INIT(8'h00), .TIMEOUT(20)) dut (
    .ulpi_clk(clk), .ulpi_rst(rst), .bus(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever @(posedge clk) cyc++;
  function automatic logic [7:0] phy_f(input logic [7:0] a);
    return a == 8'h00 ? 8'h24 : a ^ 8'h4C;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic push_init();
    exp_reg.push_back({1'b1, 8'h04, 8'h45});
    exp_reg.push_back({1'b1, 8'h0A, 8'h00});
    exp_reg.push_back({1'b0, 8'h00, 8'h00});
  endtask
  task automatic flush();
    exp_reg.delete();
    exp_a.delete();
    exp_b.delete();
  endtask
  task automatic arm(input bit b, input bit we, input logic [7:0] addr, input logic [7:0] din, input bit srv);
    if (b) {bus.b_en, bus.b_we, bus.b_addr, bus.b_din} = {1'b1, we, addr, din};
    else {bus.a_en, bus.a_we, bus.a_addr, bus.a_din} = {1'b1, we, addr, din};
    if (srv) begin
      exp_reg.push_back({we, addr, din});
      if (b) exp_b.push_back(phy_f(addr));
      else exp_a.push_back(phy_f(addr));
    end
  endtask
  task automatic pulse();
    t_en = cyc;
    @(negedge clk);
    bus.a_en = 0;
    bus.b_en = 0;
  endtask
  task automatic wait_init();
    int n = 0;
    while (!bus.init_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("init_done", bus.init_done, 1);
    chk("phy_vid_lo", bus.phy_vid_lo, 8'h24);
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_reg.size() != 0 || exp_a.size() != 0 || exp_b.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_reg.size() + exp_a.size() + exp_b.size(), 0);
  endtask
  task automatic wait_regen(input int k);
    int n = 0;
    while (n_regen == k && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reg_en_seen", n_regen, k + 1);
  endtask
  // model ulpi_ctl + PHY: checks each reg_en against the scoreboard and answers after 6 cycles
  initial begin
    bus.reg_rdy = 0;
    bus.reg_dout = 0;
    busy = 0;
    lat = 0;
    cur = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.reg_rdy = 0;
      if (rst) busy = 0;
      else if (bus.reg_en) begin
        n_regen++;
        t_regen = cyc;
        chk("reg_en_overlap", busy, 0);
        if (exp_reg.size() == 0) chk("reg_en_extra", bus.reg_en, 0);
        else chk("reg_op", {bus.reg_we, bus.reg_addr, bus.reg_din}, exp_reg.pop_front());
        busy = 1;
        lat = 6;
        cur = bus.reg_addr;
      end else if (busy && phy_on) begin
        lat--;
        if (lat == 0) begin
          bus.reg_rdy = 1;
          bus.reg_dout = phy_f(cur);
          busy = 0;
          t_rrdy = cyc;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst && bus.a_rdy) begin
      t_ardy = cyc;
      if (exp_a.size() == 0) chk("a_rdy_extra", bus.a_rdy, 0);
      else chk("a_dout", bus.a_dout, exp_a.pop_front());
    end
    if (!rst && bus.b_rdy) begin
      if (exp_b.size() == 0) chk("b_rdy_extra", bus.b_rdy, 0);
      else chk("b_dout", bus.b_dout, exp_b.pop_front());
    end
  end
  initial begin
    int k, tr;
    {bus.a_en, bus.a_we, bus.a_addr, bus.a_din} = '0;
    {bus.b_en, bus.b_we, bus.b_addr, bus.b_din} = '0;
    phy_on = 1;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_reg_en", bus.reg_en, 0);
    chk("rst_reg_addr", bus.reg_addr, 0);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_vid", bus.phy_vid_lo, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_rdy", {bus.a_rdy, bus.b_rdy}, 0);
    push_init();
    rst = 0;
    @(negedge clk);
    arm(1, 1, 8'h33, 8'h77, 1);
    pulse();
    arm(1, 0, 8'h55, 8'h00, 0);
    pulse();
    chk("init_early", bus.init_done, 0);
    wait_init();
    drain();
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      arm(0, 1, 8'h10 + 8'(i), 8'hA0 + 8'(i), 1);
      arm(1, 0, 8'h20 + 8'(i), 8'h00, 1);
      pulse();
      drain();
    end
    arm(0, 0, 8'h16, 8'h00, 1);
    pulse();
    drain();
    chk("en_to_reg_en", t_regen - t_en, 2);
    chk("reg_rdy_to_a_rdy", t_ardy - t_rrdy, 1);
    repeat (10) @(negedge clk);
    chk("a_dout_held", bus.a_dout, 8'h5A);
    phy_on = 0;
    k = n_regen;
    exp_reg.push_back({1'b0, 8'h61, 8'h00});
    arm(0, 0, 8'h61, 8'h00, 0);
    pulse();
    wait_regen(k);
    tr = t_regen;
    arm(1, 1, 8'h62, 8'h01, 0);
    pulse();
    while (cyc < tr + 15) @(negedge clk);
    chk("timeout_early", bus.timeout, 0);
    while (cyc < tr + 25) @(negedge clk);
    chk("timeout_set", bus.timeout, 1);
    chk("no_reissue", n_regen, k + 1);
    rst = 1;
    #1;
    chk("timeout_clr", bus.timeout, 0);
    flush();
    phy_on = 1;
    repeat (2) @(negedge clk);
    push_init();
    rst = 0;
    wait_init();
    drain();
    k = n_regen;
    exp_reg.push_back({1'b0, 8'h40, 8'h00});
    arm(0, 0, 8'h40, 8'h00, 0);
    pulse();
    wait_regen(k);
    repeat (2) @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("arst_reg", {bus.reg_en, bus.reg_we, bus.reg_addr, bus.reg_din}, 0);
    chk("arst_dout", {bus.a_rdy, bus.b_rdy, bus.a_dout, bus.b_dout}, 0);
    chk("arst_status", {bus.init_done, bus.timeout, bus.phy_vid_lo}, 0);
    flush();
    repeat (2) @(negedge clk);
    push_init();
    rst = 0;
    wait_init();
    drain();
    repeat (20) @(negedge clk);
    chk("final_queues", exp_reg.size() + exp_a.size() + exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ulpi_reg_sched.md
# ulpi_reg_sched

Sequencer and arbiter for the ULPI PHY register port of `ulpi_ctl`. After reset it waits for the PHY, then runs a fixed init sequence: write Function Control, write OTG Control, read Vendor ID low. It then shares the single register port between two requesters, A and B, using round-robin arbitration. A watchdog flags register transactions that never complete.

## Interface
Parameters:
- `INIT_DELAY`, 16: cycles to wait after reset release before the first init access (1..65535).
- `FUNC_CTL_INIT`, 8'h45: data written to Function Control, addr 0x04 (FS, TermSelect, SuspendM).
- `OTG_CTL_INIT`, 8'h00: data written to OTG Control, addr 0x0A.
- `TIMEOUT`, 1023: cycles in a wait state before `timeout` is set (1..65535).

Ports:
- `ulpi_clk` in 1: clock. All logic runs in this single domain.
- `ulpi_rst` in 1: reset, asynchronous, active-high.
- `a_en`, `b_en` in 1: one-cycle request strobe.
- `a_we`, `b_we` in 1: 1 = write, 0 = read. Sampled with `*_en`.
- `a_addr`, `b_addr` in 8: register address. Sampled with `*_en`.
- `a_din`, `b_din` in 8: write data. Sampled with `*_en`.
- `a_rdy`, `b_rdy` out 1: one-cycle completion strobe.
- `a_dout`, `b_dout` out 8: read data. Valid with `*_rdy` and held until that requester's next completion.
- `reg_en` out 1: to `ulpi_ctl`. One-cycle strobe, registered.
- `reg_we` out 1, `reg_addr` out 8, `reg_din` out 8: to `ulpi_ctl`. Registered; stable from `reg_en` until `reg_rdy`.
- `reg_rdy` in 1, `reg_dout` in 8: from `ulpi_ctl`.
- `init_done` out 1: high once the init sequence completes; stays high until reset.
- `phy_vid_lo` out 8: Vendor ID low byte captured during init.
- `timeout` out 1: sticky watchdog flag, cleared only by reset.

## Operation
- Reset values:
  - All strobes 0.
  - `reg_we`, `reg_addr`, `reg_din` = 0.
  - `a_dout`, `b_dout`, `phy_vid_lo` = 0.
  - `init_done` = 0, `timeout` = 0.
  - Pending flags cleared; `last_grant` = B, so A wins the first tie.
  - State = DELAY, delay counter = 0.
- Request capture:
  - `x_en` while x has no pending request sets pending_x and latches we/addr/din.
  - `x_en` while pending_x is set is ignored: no latch, no completion.
  - Capture works in every state, including DELAY and init. Captured requests are served after `init_done`.
- States:
  - DELAY: counts to `INIT_DELAY`-1, then goes to INIT_ISSUE with step = 0.
  - INIT_ISSUE: drives `reg_en`=1 for one cycle with step's op, then goes to INIT_WAIT. The ops are:
    - step 0: write 0x04 / `FUNC_CTL_INIT`
    - step 1: write 0x0A / `OTG_CTL_INIT`
    - step 2: read 0x00
  - INIT_WAIT: on `reg_rdy`, for step 2 latch `reg_dout` into `phy_vid_lo`.
    - If step < 2: step+1, go to INIT_ISSUE.
    - Otherwise: set `init_done`, go to IDLE.
  - IDLE: if any request is pending, select the winner and go to ISSUE.
    - Winner is the sole pending requester, or the one not equal to `last_grant` when both are pending.
    - Update `last_grant` to the winner.
  - ISSUE: drives `reg_en`=1 with the winner's latched op, then goes to WAIT.
  - WAIT: on `reg_rdy`, the next cycle does all of the following, and the state returns to IDLE:
    - pulse the winner's `*_rdy`
    - load its `*_dout` from `reg_dout` for both reads and writes
    - clear its pending flag
- Watchdog:
  - A 16-bit counter clears on entry to INIT_WAIT or WAIT and increments while in either state.
  - When it reaches `TIMEOUT` without `reg_rdy`, `timeout` is set. The block keeps waiting; there is no abort, because `ulpi_ctl` cannot be cancelled.
- `reg_rdy` outside INIT_WAIT/WAIT is ignored.

## Timing
- `reg_en` is high exactly one cycle per transaction. There is never a second `reg_en` before the matching `reg_rdy`.
- Minimum latency from `x_en` (cycle t) to `reg_en` is 2 cycles: pending at t+1, IDLE grants, ISSUE at t+2.
- `reg_rdy` at cycle k gives `x_rdy` at k+1 and IDLE at k+1. The earliest next `reg_en` is at k+2, which is when `ulpi_ctl` is back in IDLE.
- The first init `reg_en` occurs at cycle `INIT_DELAY`+1 after reset release.
- New `x_en` in the same cycle as `x_rdy` is accepted, because pending clears at that edge.
- Asynchronous reset mid-transaction aborts everything. No `*_rdy` is issued for lost requests, and init reruns from DELAY.

## Test plan
- Reset, `INIT_DELAY`=4, model PHY `reg_rdy` 6 cycles after `reg_en`, VID low 0x24 → `reg_en` sequence is:
  - write 0x04/0x45
  - write 0x0A/0x00
  - read 0x00
  - Then `phy_vid_lo`=0x24 and `init_done`=1.
- After init, `a_en` read addr 0x16, model returns 0x5A → `reg_en` 2 cycles after `a_en`; `a_rdy` 1 cycle after `reg_rdy`; `a_dout`=0x5A and held.
- `a_en` and `b_en` in the same cycle, repeated 3 times → grants are A, B, A, B, A, B.
- `b_en` issued during DELAY → served only after `init_done`. A second `b_en` while pending is ignored: only one `b_rdy`.
- `TIMEOUT`=20, model never asserts `reg_rdy` → `timeout`=1 at cycle 20 of WAIT; no further `reg_en`; reset clears `timeout`.
- Assert `ulpi_rst` during WAIT → all outputs return to reset values immediately, and init restarts after release.
